gpio_bank: RTL and testbench
============================

Name: gpio_bank

Overview:
- Parametrised multi-channel GPIO bank; successor to the fixed four-register GPIO out/in pair.
- N channels of WIDTH bits, each with output-data, direction, synchronised input and rising-edge interrupt-status registers.
- Sits between the simple register bus (sel/wen/ren/addr) and the pad ring; tristate buffers live at top level, driven by gpio_o/gpio_oe.

Parameters:
- WIDTH, 32, bits per channel
- N, 4, number of channels (1..16, not necessarily a power of two)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- AW, $clog2(N)+2 (derived, localparam), address width

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- sel  input  1  block select
- wen  input  1  write strobe, qualified by sel
- ren  input  1  read strobe, qualified by sel
- addr  input  AW  {channel, reg[1:0]}
- wdata  input  WIDTH  write data
- rdata  output  WIDTH  registered read data
- rvalid  output  1  one-cycle read-data-valid pulse
- gpio_i  input  N*WIDTH  raw pad inputs (asynchronous); channel c occupies bits [c*WIDTH +: WIDTH]
- gpio_o  output  N*WIDTH  pad output values
- gpio_oe  output  N*WIDTH  pad output enables, 1 = drive
- irq  output  1  OR of all interrupt-status bits

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rstn).
- Register map, per channel c = addr[AW-1:2]:
  - reg 0, DOUT: RW.
  - reg 1, DIR: RW; 1 = output.
  - reg 2, DIN: RO; synchronised pin value.
  - reg 3, ISTAT: W1C.
- Reset values (asynchronous on rstn low): DOUT=0, DIR=0 (all inputs), ISTAT=0, synchroniser flops=0, rdata=0, rvalid=0, irq=0. Hence gpio_o=0 and gpio_oe=0.
- Reset asserted mid-operation clears all state immediately; any pending read is dropped (no rvalid).
- Writes (sel&wen at edge k):
  - DOUT/DIR update at edge k; gpio_o/gpio_oe reflect the new value after edge k.
  - gpio_o = DOUT, gpio_oe = DIR, both driven directly from registers with no extra stage.
- Reads (sel&ren at edge k): rdata and rvalid are valid after edge k (1-cycle latency).
  - rvalid is high for exactly one cycle per read.
  - Back-to-back reads are allowed every cycle.
  - rdata holds its last value when rvalid=0.
- Simultaneous sel&wen&ren to the same register: write takes effect; rdata returns the pre-write value.
- Writes to DIN are ignored.
- Channel index >= N (non-power-of-two N): writes ignored; reads return 0 with rvalid=1.
- Input path: gpio_i passes through a SYNC_STAGES flop chain. A pin change appears in DIN after SYNC_STAGES edges. DIN reports the synchronised pin value regardless of DIR.
- Edge detect: one extra flop holds the previous synchronised value; rise = sync & ~prev.
- No wrap-around counters; all arithmetic is address decode only. addr bits above AW do not exist.

Optional Feature:
- Macro GPIO_BANK_IRQ_EN.
- Defined:
  - ISTAT[b] sets on a rising edge of synchronised bit b when DIR[b]=0.
  - Cleared by writing 1 to that bit.
  - Set and clear in the same cycle: set wins.
  - irq = |ISTAT (all channels), registered, asserted the cycle after a status bit sets.
  - Output-direction bits never set ISTAT.
- Undefined: no edge-detect flops or ISTAT storage; reg 3 reads 0, writes are ignored, irq is tied 0.

Test Plan:
- Reset, then read all regs of channels 0..N-1 -> all rdata=0, rvalid pulses once per read; gpio_o=0, gpio_oe=0.
- Write DIR ch2=0xFFFF0000, then DOUT ch2=0xA5A5A5A5 -> gpio_oe[95:64]=0xFFFF0000 and gpio_o[95:64]=0xA5A5A5A5 after the write edge; other channels unchanged.
- Drive gpio_i[31:0]=0x0000000F at edge k -> DIN ch0 reads 0x0000000F from a read issued at edge k+2 onward; a read at edge k+1 returns 0.
- GPIO_BANK_IRQ_EN, DIR ch1=0, raise gpio_i bit 32 -> ISTAT ch1=0x1 and irq=1. Write ch1 ISTAT=0x1 -> ISTAT=0, irq=0. A rising edge coinciding with the clear keeps ISTAT=1.
- Simultaneous write+read DOUT ch3 (old 0x1, new 0x2) -> rdata=0x1; the next read returns 0x2. With N=3, a write to channel 3 is ignored and its read returns 0 with rvalid=1.
- Pulse rstn low asynchronously mid-stream, with a read issued the same cycle -> all outputs 0 immediately, no rvalid; DIR/DOUT read 0 after rstn is released.

Source files
------------

// File: rtl/gpio_bank.sv
// Parametrised N-channel GPIO bank: DOUT/DIR/DIN/ISTAT per channel.
// Define GPIO_BANK_IRQ_EN to build rising-edge interrupt status and irq.
module gpio_bank #(
   parameter int WIDTH       = 32,
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2,
   localparam int AW         = $clog2(N) + 2
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               sel,
   input  logic               wen,
   input  logic               ren,
   input  logic [AW-1:0]      addr,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   rdata,
   output logic               rvalid,
   input  logic [N*WIDTH-1:0] gpio_i,
   output logic [N*WIDTH-1:0] gpio_o,
   output logic [N*WIDTH-1:0] gpio_oe,
   output logic               irq
);

   localparam int NW = N * WIDTH;

   logic                          wr;
   logic                          rd;
   logic [AW-1:0]                 ch_idx;
   logic [1:0]                    reg_sel;
   logic [SYNC_STAGES-1:0][NW-1:0] sync_q;
   logic [SYNC_STAGES-1:0][NW-1:0] sync_d;
   logic [NW-1:0]                 din;
   logic [WIDTH-1:0][N-1:0]       rd_t;
   logic [WIDTH-1:0]              rd_mux;
   logic [WIDTH-1:0]              rdata_q;
   logic [WIDTH-1:0]              rdata_d;
   logic                          rvalid_q;
   logic                          rvalid_d;

   assign wr      = sel & wen;
   assign rd      = sel & ren;
   assign ch_idx  = addr >> 2;
   assign reg_sel = addr[1:0];

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], gpio_i};
   end

   assign din = sync_q[SYNC_STAGES-1];

`ifdef GPIO_BANK_IRQ_EN
   logic [N-1:0] ch_irq;
   logic         irq_q;
   logic         irq_d;
`endif

   for (genvar c = 0; c < N; c++) begin : g_ch
      logic             hit;
      logic [WIDTH-1:0] dout_q;
      logic [WIDTH-1:0] dout_d;
      logic [WIDTH-1:0] dir_q;
      logic [WIDTH-1:0] dir_d;
      logic [WIDTH-1:0] din_c;
      logic [WIDTH-1:0] istat_v;
      logic [WIDTH-1:0] rval;

      // out-of-range channels never match, so their accesses fall through
      assign hit   = (ch_idx == AW'(c));
      assign din_c = din[c*WIDTH +: WIDTH];

      always_comb begin
         dout_d = dout_q;
         dir_d  = dir_q;
         if (wr && hit && reg_sel == 2'd0) dout_d = wdata;
         if (wr && hit && reg_sel == 2'd1) dir_d = wdata;
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            dout_q <= '0;
            dir_q  <= '0;
         end else begin
            dout_q <= dout_d;
            dir_q  <= dir_d;
         end
      end

`ifdef GPIO_BANK_IRQ_EN
      logic [WIDTH-1:0] prev_q;
      logic [WIDTH-1:0] prev_d;
      logic [WIDTH-1:0] istat_q;
      logic [WIDTH-1:0] istat_d;
      logic [WIDTH-1:0] clr;

      // a rise in the same cycle as a clear keeps the bit set
      always_comb begin
         prev_d  = din_c;
         clr     = (wr && hit && reg_sel == 2'd3) ? wdata : '0;
         istat_d = (istat_q & ~clr) | (din_c & ~prev_q & ~dir_q);
      end

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            prev_q  <= '0;
            istat_q <= '0;
         end else begin
            prev_q  <= prev_d;
            istat_q <= istat_d;
         end
      end

      assign istat_v   = istat_q;
      assign ch_irq[c] = |istat_q;
`else
      assign istat_v = '0;
`endif

      always_comb begin
         unique case (reg_sel)
            2'd0:    rval = dout_q;
            2'd1:    rval = dir_q;
            2'd2:    rval = din_c;
            default: rval = istat_v;
         endcase
      end

      for (genvar b = 0; b < WIDTH; b++) begin : g_bit
         assign rd_t[b][c] = hit & rval[b];
      end

      assign gpio_o[c*WIDTH +: WIDTH]  = dout_q;
      assign gpio_oe[c*WIDTH +: WIDTH] = dir_q;
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_or
      assign rd_mux[b] = |rd_t[b];
   end

   always_comb begin
      rvalid_d = rd;
      rdata_d  = rd ? rd_mux : rdata_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

`ifdef GPIO_BANK_IRQ_EN
   assign irq_d = |ch_irq;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) irq_q <= 1'b0;
      else       irq_q <= irq_d;
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank: N=4 main instance plus an N=3 instance
// for out-of-range channel behaviour.
module tb_gpio_bank;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         sel = 1'b0;
   logic         wen = 1'b0;
   logic         ren = 1'b0;
   logic [3:0]   addr = '0;
   logic [31:0]  wdata = '0;
   logic [127:0] gpio_i = '0;

   logic [31:0]  rdata;
   logic         rvalid;
   logic [127:0] gpio_o;
   logic [127:0] gpio_oe;
   logic         irq;

   logic [31:0]  rdata3;
   logic         rvalid3;
   logic [95:0]  gpio_o3;
   logic [95:0]  gpio_oe3;
   logic         irq3;
   logic [95:0]  gpio_i3;

   logic [31:0]  rd4;
   logic         rv4;
   logic [31:0]  rd3;
   logic         rv3;

   int checks = 0;
   int failures = 0;

   assign gpio_i3 = gpio_i[95:0];

   always #5 clk = ~clk;

   gpio_bank #(.WIDTH(32), .N(4), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rstn(rstn), .sel(sel), .wen(wen), .ren(ren),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
   );

   gpio_bank #(.WIDTH(32), .N(3), .SYNC_STAGES(2)) u_dut3 (
      .clk(clk), .rstn(rstn), .sel(sel), .wen(wen), .ren(ren),
      .addr(addr), .wdata(wdata), .rdata(rdata3), .rvalid(rvalid3),
      .gpio_i(gpio_i3), .gpio_o(gpio_o3), .gpio_oe(gpio_oe3), .irq(irq3)
   );

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; wen = 1'b1; ren = 1'b0; addr = a; wdata = d;
      @(negedge clk);
      sel = 1'b0; wen = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a);
      @(negedge clk);
      sel = 1'b1; ren = 1'b1; wen = 1'b0; addr = a;
      @(posedge clk);
      #1;
      rd4 = rdata; rv4 = rvalid; rd3 = rdata3; rv3 = rvalid3;
      @(negedge clk);
      sel = 1'b0; ren = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (gpio_o !== '0 || gpio_oe !== '0) begin
         failures++;
         $display("FAIL reset_pads o=%h oe=%h want 0", gpio_o, gpio_oe);
      end
      checks++;
      if (rdata !== '0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_outs rdata=%h rvalid=%b irq=%b want 0",
                  rdata, rvalid, irq);
      end
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         sel = 1'b1; ren = 1'b1; addr = 4'(i);
         @(posedge clk);
         #1;
         checks++;
         if (rdata !== '0 || rvalid !== 1'b1) begin
            failures++;
            $display("FAIL reset_read a=%0d rdata=%h rvalid=%b want 0/1",
                     i, rdata, rvalid);
         end
      end
      @(negedge clk);
      sel = 1'b0; ren = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rvalid !== 1'b0) begin
         failures++;
         $display("FAIL reset_rvalid_idle rvalid=%b want 0", rvalid);
      end
   endtask

   task automatic test_dir_dout();
      bus_write(4'd9, 32'hFFFF0000);
      checks++;
      if (gpio_oe !== {32'h0, 32'hFFFF0000, 64'h0}) begin
         failures++;
         $display("FAIL dir_oe got=%h want=%h", gpio_oe,
                  {32'h0, 32'hFFFF0000, 64'h0});
      end
      bus_write(4'd8, 32'hA5A5A5A5);
      checks++;
      if (gpio_o !== {32'h0, 32'hA5A5A5A5, 64'h0}) begin
         failures++;
         $display("FAIL dout_o got=%h want=%h", gpio_o,
                  {32'h0, 32'hA5A5A5A5, 64'h0});
      end
      bus_read(4'd9);
      checks++;
      if (rd4 !== 32'hFFFF0000 || rv4 !== 1'b1) begin
         failures++;
         $display("FAIL dir_read got=%h v=%b want=FFFF0000", rd4, rv4);
      end
   endtask

   task automatic test_sync();
      @(negedge clk);
      gpio_i[31:0]  = 32'h0000000F;
      gpio_i[95:64] = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      sel = 1'b1; ren = 1'b1; addr = 4'd2;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h0 || rvalid !== 1'b1) begin
         failures++;
         $display("FAIL sync_k1 got=%h v=%b want=0", rdata, rvalid);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h0000000F || rvalid !== 1'b1) begin
         failures++;
         $display("FAIL sync_k2 got=%h v=%b want=F", rdata, rvalid);
      end
      @(negedge clk);
      addr = 4'd10;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h12345678) begin
         failures++;
         $display("FAIL din_dir_out got=%h want=12345678", rdata);
      end
      @(negedge clk);
      sel = 1'b0; ren = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h12345678 || rvalid !== 1'b0) begin
         failures++;
         $display("FAIL rdata_hold got=%h v=%b want=12345678/0",
                  rdata, rvalid);
      end
      bus_write(4'd2, 32'hDEADBEEF);
      bus_read(4'd2);
      checks++;
      if (rd4 !== 32'h0000000F) begin
         failures++;
         $display("FAIL din_write got=%h want=F", rd4);
      end
   endtask

   task automatic test_irq();
`ifdef GPIO_BANK_IRQ_EN
      bus_write(4'd3, 32'hFFFFFFFF);
      bus_write(4'd11, 32'hFFFFFFFF);
      repeat (3) @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin
         failures++;
         $display("FAIL irq_cleared got=%b want=0", irq);
      end
      gpio_i[32] = 1'b1;
      repeat (5) @(negedge clk);
      bus_read(4'd7);
      checks++;
      if (rd4 !== 32'h1 || irq !== 1'b1) begin
         failures++;
         $display("FAIL istat_set got=%h irq=%b want=1/1", rd4, irq);
      end
      bus_write(4'd7, 32'h1);
      repeat (2) @(negedge clk);
      bus_read(4'd7);
      checks++;
      if (rd4 !== 32'h0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL istat_clr got=%h irq=%b want=0/0", rd4, irq);
      end
      gpio_i[32] = 1'b0;
      repeat (4) @(negedge clk);
      gpio_i[32] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      sel = 1'b1; wen = 1'b1; addr = 4'd7; wdata = 32'h1;
      @(posedge clk);
      @(negedge clk);
      sel = 1'b0; wen = 1'b0;
      bus_read(4'd7);
      checks++;
      if (rd4 !== 32'h1) begin
         failures++;
         $display("FAIL set_wins got=%h want=1", rd4);
      end
      bus_write(4'd7, 32'h1);
      bus_write(4'd5, 32'h2);
      gpio_i[33] = 1'b1;
      repeat (5) @(negedge clk);
      bus_read(4'd7);
      checks++;
      if (rd4 !== 32'h0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL out_no_istat got=%h irq=%b want=0/0", rd4, irq);
      end
`else
      gpio_i[32] = 1'b1;
      repeat (5) @(negedge clk);
      bus_write(4'd7, 32'hFFFFFFFF);
      bus_read(4'd7);
      checks++;
      if (rd4 !== 32'h0 || irq !== 1'b0 || irq3 !== 1'b0) begin
         failures++;
         $display("FAIL istat_off got=%h irq=%b want=0/0", rd4, irq);
      end
`endif
   endtask

   task automatic test_back_to_back();
      bus_write(4'd12, 32'h1);
      @(negedge clk);
      sel = 1'b1; wen = 1'b1; ren = 1'b1; addr = 4'd12; wdata = 32'h2;
      @(posedge clk);
      #1;
      checks++;
      if (rdata !== 32'h1 || rvalid !== 1'b1) begin
         failures++;
         $display("FAIL rw_same got=%h v=%b want=1/1", rdata, rvalid);
      end
      checks++;
      if (gpio_o[127:96] !== 32'h2) begin
         failures++;
         $display("FAIL rw_same_o got=%h want=2", gpio_o[127:96]);
      end
      checks++;
      if (rdata3 !== 32'h0 || rvalid3 !== 1'b1) begin
         failures++;
         $display("FAIL n3_oob_read got=%h v=%b want=0/1", rdata3, rvalid3);
      end
      @(negedge clk);
      sel = 1'b0; wen = 1'b0; ren = 1'b0;
      bus_read(4'd12);
      checks++;
      if (rd4 !== 32'h2) begin
         failures++;
         $display("FAIL rw_next got=%h want=2", rd4);
      end
      checks++;
      if (gpio_o3 !== {32'hA5A5A5A5, 64'h0} ||
          gpio_oe3 !== {32'hFFFF0000, 64'h0}) begin
         failures++;
         $display("FAIL n3_oob_write o=%h oe=%h", gpio_o3, gpio_oe3);
      end
   endtask

   task automatic test_reset_mid();
      bus_read(4'd8);
      @(negedge clk);
      sel = 1'b1; ren = 1'b1; addr = 4'd8;
      #2;
      rstn = 1'b0;
      #1;
      checks++;
      if (gpio_o !== '0 || gpio_oe !== '0) begin
         failures++;
         $display("FAIL midrst_pads o=%h oe=%h want 0", gpio_o, gpio_oe);
      end
      checks++;
      if (rdata !== '0 || rvalid !== 1'b0 || irq !== 1'b0) begin
         failures++;
         $display("FAIL midrst_outs rdata=%h v=%b irq=%b want 0",
                  rdata, rvalid, irq);
      end
      @(posedge clk);
      #1;
      checks++;
      if (rvalid !== 1'b0) begin
         failures++;
         $display("FAIL midrst_rvalid got=%b want=0", rvalid);
      end
      @(negedge clk);
      rstn = 1'b1; sel = 1'b0; ren = 1'b0;
      bus_read(4'd8);
      checks++;
      if (rd4 !== 32'h0 || rv4 !== 1'b1) begin
         failures++;
         $display("FAIL midrst_dout got=%h v=%b want=0/1", rd4, rv4);
      end
      bus_read(4'd9);
      checks++;
      if (rd4 !== 32'h0) begin
         failures++;
         $display("FAIL midrst_dir got=%h want=0", rd4);
      end
   endtask

   initial begin
      test_reset();
      test_dir_dout();
      test_sync();
      test_irq();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
